// File: rtl/ps_sample_sequencer_if.sv
// Handshake with the PS reader plus the published-reading bus toward the level comparator.
// master = sequencer side, slave = reader / comparator side.
interface ps_sample_sequencer_if;
   logic        ps_req;
   logic        ps_ack;
   logic [17:0] ps_data_in;
   logic [17:0] ps_avg;
   logic        ps_valid;

   modport master (
      output ps_req,
      output ps_avg,
      output ps_valid,
      input  ps_ack,
      input  ps_data_in
   );

   modport slave (
      input  ps_req,
      input  ps_avg,
      input  ps_valid,
      output ps_ack,
      output ps_data_in
   );
endinterface

// File: rtl/ps_sample_sequencer.sv
// Paces proximity-sensor reads, times out unanswered requests and publishes each reading.
// Define PS_AVG_EN to box-average 2**AVG_LOG2 readings per published word.
module ps_sample_sequencer #(
   parameter int PERIOD_CYC  = 500000,
   parameter int TIMEOUT_CYC = 65535,
   parameter int AVG_LOG2    = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         enable,
   ps_sample_sequencer_if.master        ps,
   output logic                         busy,
   output logic [7:0]                   err_cnt
);
   localparam int CNT_W = $clog2(PERIOD_CYC);
   localparam int TO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   if (PERIOD_CYC < 4 || TIMEOUT_CYC < 1 || AVG_LOG2 < 0 || AVG_LOG2 > 4) begin : g_param_check
      $error("ps_sample_sequencer: parameter out of range");
   end

   typedef enum logic {IDLE = 1'b0, WAIT_ACK = 1'b1} state_t;

   state_t            state_reg, state_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;
   logic [TO_W-1:0]   tcnt_reg, tcnt_next;
   logic [7:0]        err_reg, err_next;
   logic [17:0]       avg_reg, avg_next;
   logic              valid_reg, valid_next;
   logic              tick;

`ifdef PS_AVG_EN
   localparam int ACC_W   = 18 + AVG_LOG2;
   localparam int NSAMP_W = AVG_LOG2 + 1;

   logic [ACC_W-1:0]   accum_reg, accum_next;
   logic [NSAMP_W-1:0] nsamp_reg, nsamp_next;
   logic [ACC_W-1:0]   sum;

   // 2**AVG_LOG2 readings of 18 bits cannot overflow ACC_W bits
   assign sum = accum_reg + ACC_W'(ps.ps_data_in);
`endif

   assign tick = (cnt_reg == CNT_W'(PERIOD_CYC - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         tcnt_reg  <= '0;
         err_reg   <= '0;
         avg_reg   <= '0;
         valid_reg <= 1'b0;
`ifdef PS_AVG_EN
         accum_reg <= '0;
         nsamp_reg <= '0;
`endif
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         tcnt_reg  <= tcnt_next;
         err_reg   <= err_next;
         avg_reg   <= avg_next;
         valid_reg <= valid_next;
`ifdef PS_AVG_EN
         accum_reg <= accum_next;
         nsamp_reg <= nsamp_next;
`endif
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      tcnt_next  = tcnt_reg;
      err_next   = err_reg;
      avg_next   = avg_reg;
      valid_next = 1'b0;
`ifdef PS_AVG_EN
      accum_next = accum_reg;
      nsamp_next = nsamp_reg;
`endif
      if (!enable) begin
         // disabling abandons any request and any partial average
         state_next = IDLE;
         cnt_next   = '0;
         tcnt_next  = '0;
`ifdef PS_AVG_EN
         accum_next = '0;
         nsamp_next = '0;
`endif
      end else begin
         cnt_next = tick ? '0 : cnt_reg + CNT_W'(1);
         case (state_reg)
            IDLE: begin
               if (tick) begin
                  state_next = WAIT_ACK;
                  tcnt_next  = '0;
               end
            end
            WAIT_ACK: begin
               // an ACK in the last allowed cycle beats the timeout
               if (ps.ps_ack) begin
                  state_next = IDLE;
`ifdef PS_AVG_EN
                  if (nsamp_reg == NSAMP_W'((1 << AVG_LOG2) - 1)) begin
                     avg_next   = 18'(sum >> AVG_LOG2);
                     valid_next = 1'b1;
                     accum_next = '0;
                     nsamp_next = '0;
                  end else begin
                     accum_next = sum;
                     nsamp_next = nsamp_reg + NSAMP_W'(1);
                  end
`else
                  avg_next   = ps.ps_data_in;
                  valid_next = 1'b1;
`endif
               end else if (tcnt_reg == TO_W'(TIMEOUT_CYC - 1)) begin
                  state_next = IDLE;
                  if (err_reg != 8'hFF) begin
                     err_next = err_reg + 8'd1;
                  end
               end else begin
                  tcnt_next = tcnt_reg + TO_W'(1);
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   assign ps.ps_req   = (state_reg == WAIT_ACK);
   assign busy        = (state_reg == WAIT_ACK);
   assign ps.ps_avg   = avg_reg;
   assign ps.ps_valid = valid_reg;
   assign err_cnt     = err_reg;
endmodule
